// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: binary-to-BCD (sequential double dabble) and
// time-multiplexed 7-seg digit scan with optional leading-zero blanking.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   async active-high reset
//   load           in   start a conversion of `value` (accepted in IDLE only)
//   value          in   binary value to convert
//   blank_leading  in   1 = leading zero digits shown as code 4'hF
//   busy           out  conversion in progress (CONVERT or DONE)
//   bcd_valid      out  1-cycle pulse when new digits are committed
//   overflow       out  last accepted value exceeded 10^DIGITS-1
//   digit_data     out  BCD code of the currently enabled digit
//   digit_en       out  active-low one-hot digit enable
module display_scan_ctrl #(
  parameter int DIGITS      = 4,
  parameter int VALUE_W     = 14,
  parameter int REFRESH_DIV = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [VALUE_W-1:0] value,
  input  logic               blank_leading,
  output logic               busy,
  output logic               bcd_valid,
  output logic               overflow,
  output logic [3:0]         digit_data,
  output logic [DIGITS-1:0]  digit_en
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int RC_W  = $clog2(REFRESH_DIV);
  localparam int BC_W  = $clog2(VALUE_W + 1);

  function automatic longint unsigned max_disp();
    longint unsigned r;
    r = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r = r * 10;
    end
    return r - 1;
  endfunction

  localparam longint unsigned MAX_VAL = max_disp();

  localparam logic [RC_W-1:0]  RC_MAX  = RC_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [VALUE_W-1:0] shift_q, shift_d;
  logic [VALUE_W-1:0] value_q, value_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BC_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [BCD_W-1:0]   disp_q, disp_d;
  logic               overflow_q, overflow_d;
  logic               bcd_valid_q, bcd_valid_d;

  logic [RC_W-1:0]    rcnt_q, rcnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DIGITS-1:0]  digit_en_q, digit_en_d;
  logic [3:0]         digit_data_q, digit_data_d;

  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_step;
  logic               ovf;
  logic [DIGITS-1:0]  blank_v;
  logic               lz;

  // One double-dabble step: +3 on every nibble >= 5, then shift in
  // the next binary MSB.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_step = (bcd_adj << 1) | BCD_W'(shift_q[VALUE_W-1]);
    ovf      = 64'(value_q) > MAX_VAL;
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    value_d     = value_q;
    bcd_d       = bcd_q;
    bit_cnt_d   = bit_cnt_q;
    disp_d      = disp_q;
    overflow_d  = overflow_q;
    bcd_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          shift_d   = value;
          value_d   = value;
          bcd_d     = '0;
          bit_cnt_d = BC_W'(VALUE_W);
          state_d   = S_CONVERT;
        end
      end
      S_CONVERT: begin
        shift_d   = shift_q << 1;
        bcd_d     = bcd_step;
        bit_cnt_d = bit_cnt_q - BC_W'(1);
        // Commit on the last step so DONE already shows the new result.
        if (bit_cnt_q == BC_W'(1)) begin
          state_d     = S_DONE;
          bcd_valid_d = 1'b1;
          overflow_d  = ovf;
          disp_d      = ovf ? {BCD_W{1'b1}} : bcd_step;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Scan: slot counter, digit index, and the registered enable/data
  // pair computed from the same next index so they never skew.
  always_comb begin
    rcnt_d = rcnt_q + RC_W'(1);
    idx_d  = idx_q;
    if (rcnt_q == RC_MAX) begin
      rcnt_d = '0;
      idx_d  = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
    end

    blank_v = '0;
    lz      = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz         = lz & (disp_q[4*i +: 4] == 4'h0);
      blank_v[i] = lz & (i != 0);
    end

    digit_data_d = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        digit_data_d = (blank_leading & blank_v[i]) ? 4'hF
                                                    : disp_q[4*i +: 4];
      end
    end
    digit_en_d = ~(DIGITS'(1) << idx_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      value_q      <= '0;
      bcd_q        <= '0;
      bit_cnt_q    <= '0;
      disp_q       <= '0;
      overflow_q   <= 1'b0;
      bcd_valid_q  <= 1'b0;
      rcnt_q       <= '0;
      idx_q        <= '0;
      digit_en_q   <= ~DIGITS'(1);
      digit_data_q <= 4'h0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      value_q      <= value_d;
      bcd_q        <= bcd_d;
      bit_cnt_q    <= bit_cnt_d;
      disp_q       <= disp_d;
      overflow_q   <= overflow_d;
      bcd_valid_q  <= bcd_valid_d;
      rcnt_q       <= rcnt_d;
      idx_q        <= idx_d;
      digit_en_q   <= digit_en_d;
      digit_data_q <= digit_data_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign bcd_valid  = bcd_valid_q;
  assign overflow   = overflow_q;
  assign digit_data = digit_data_q;
  assign digit_en   = digit_en_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: scoreboard bench for display_scan_ctrl.
// Decimal reference model, queue of expected commits, per-cycle monitor.
module tb_display_scan_ctrl;

  localparam int DIGITS  = 4;
  localparam int VALUE_W = 14;
  localparam int DIV     = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               load = 1'b0;
  logic [VALUE_W-1:0] value = '0;
  logic               blank_leading = 1'b0;
  logic               busy;
  logic               bcd_valid;
  logic               overflow;
  logic [3:0]         digit_data;
  logic [DIGITS-1:0]  digit_en;

  display_scan_ctrl #(
    .DIGITS(DIGITS),
    .VALUE_W(VALUE_W),
    .REFRESH_DIV(DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load(load),
    .value(value),
    .blank_leading(blank_leading),
    .busy(busy),
    .bcd_valid(bcd_valid),
    .overflow(overflow),
    .digit_data(digit_data),
    .digit_en(digit_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          ovf;
    logic [15:0] digs;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          ncyc = 0;
  int          free_edge = 0;
  int          busy_lo = 1;
  int          busy_hi = 0;
  logic [15:0] shown = '0;
  bit          ovf_m = 1'b0;
  bit          blank_s = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) ncyc <= 0;
    else     ncyc <= ncyc + 1;
  end

  always @(posedge clk) blank_s <= blank_leading;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, ncyc);
    end
  endtask

  function automatic logic [3:0] exp_digit(logic [15:0] s, int i, bit b);
    bit hi_zero;
    hi_zero = 1'b1;
    for (int j = i; j < DIGITS; j++) begin
      if (s[4*j +: 4] != 4'h0) hi_zero = 1'b0;
    end
    if (b && i != 0 && hi_zero) return 4'hF;
    return s[4*i +: 4];
  endfunction

  always @(negedge clk) begin : mon
    int          idx;
    exp_t        e;
    logic [3:0]  en_e;
    bit          exp_v;
    idx  = (ncyc / DIV) % DIGITS;
    en_e = ~(4'b0001 << idx);
    if (rst) begin
      q.delete();
      shown = '0;
      ovf_m = 1'b0;
      check("rst_digit_en", digit_en, 4'b1110);
      check("rst_digit_data", digit_data, 4'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_bcd_valid", bcd_valid, 1'b0);
      check("rst_overflow", overflow, 1'b0);
    end else begin
      check("digit_en", digit_en, en_e);
      check("digit_data", digit_data, exp_digit(shown, idx, blank_s));
      exp_v = (q.size() > 0) && (q[0].cyc == ncyc);
      check("bcd_valid", bcd_valid, exp_v);
      if (q.size() > 0 && q[0].cyc <= ncyc) begin
        e     = q.pop_front();
        shown = e.digs;
        ovf_m = e.ovf;
      end
      check("overflow", overflow, ovf_m);
      check("busy", busy, (ncyc >= busy_lo && ncyc <= busy_hi));
    end
  end

  task automatic do_wait(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(int v);
    int   e;
    int   p;
    exp_t x;
    @(negedge clk);
    #1;
    e = ncyc + 1;
    if (e >= free_edge) begin
      x.cyc = e + VALUE_W;
      x.ovf = (v > 9999);
      p = 1;
      for (int i = 0; i < DIGITS; i++) begin
        x.digs[4*i +: 4] = x.ovf ? 4'hF : 4'((v / p) % 10);
        p = p * 10;
      end
      q.push_back(x);
      busy_lo   = e;
      busy_hi   = e + VALUE_W;
      free_edge = e + VALUE_W + 2;
    end
    load  = 1'b1;
    value = VALUE_W'(v);
    @(negedge clk);
    #1 load = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    free_edge = 0;
    busy_lo   = 1;
    busy_hi   = 0;
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int v;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    do_load(1234);
    do_wait(40);

    do_load(10000);
    do_wait(20);
    do_load(9999);
    do_wait(40);

    blank_leading = 1'b1;
    do_load(7);
    do_wait(40);
    do_load(0);
    do_wait(40);
    blank_leading = 1'b0;
    do_load(0);
    do_wait(40);

    do_load(1234);
    do_wait(1);
    do_load(5678);
    do_wait(40);

    do_load(4321);
    do_wait(3);
    do_reset();
    do_wait(30);

    do_wait(4 * DIV * 3);

    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 3) == 0) blank_leading = ~blank_leading;
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 99);
        1:       v = $urandom_range(9990, 10010);
        default: v = $urandom_range(0, 16383);
      endcase
      do_load(v);
      do_wait($urandom_range(0, 22));
      if ($urandom_range(0, 19) == 0) do_reset();
    end

    do_wait(40);
    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
